// File: rtl/mppt_seq.sv
// Perturb-and-observe MPPT sequencer: settle/sample/multiply/compare/update loop driving a clamped duty register.
// Optional hold-off band enabled by defining MPPT_SEQ_HOLD_EN.
module mppt_seq #(
    parameter int CW        = 14,
    parameter int DW        = 10,
    parameter int DUTY_W    = 10,
    parameter int SETTLE    = 8000,
    parameter int STEP      = 4,
    parameter int DUTY_MIN  = 64,
    parameter int DUTY_MAX  = 960,
    parameter int DUTY_INIT = 512,
    parameter int HOLD_TH   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DW-1:0]     v_in,
    input  logic [DW-1:0]     i_in,
    output logic [DUTY_W-1:0] duty,
    output logic [3:0]        en,
    output logic [2:0]        state,
    output logic              dir,
    output logic [15:0]       iter
);

    localparam int PW = 2 * DW;
    localparam int NW = DUTY_W + 2;
    localparam logic signed [NW-1:0] STEP_S = NW'(STEP);
    localparam logic signed [NW-1:0] MAX_S  = NW'(DUTY_MAX);
    localparam logic signed [NW-1:0] MIN_S  = NW'(DUTY_MIN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_MULT    = 3'd3,
        ST_COMPARE = 3'd4,
        ST_UPDATE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          en_q, en_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       v_q, v_d, i_q, i_d;
    logic [PW-1:0]       p_q, p_d, pp_q, pp_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [15:0]         iter_q, iter_d;
    logic signed [NW-1:0] nd;
    logic                hold;

`ifdef MPPT_SEQ_HOLD_EN
    logic [PW-1:0] diff;
    assign diff = (p_q >= pp_q) ? (p_q - pp_q) : (pp_q - p_q);
    assign hold = (diff <= PW'(HOLD_TH));
`else
    logic unused_hold_th;
    assign unused_hold_th = (HOLD_TH != 0);
    assign hold = 1'b0;
`endif

    // Signed headroom of two bits lets over/underflow of the step be seen before clamping.
    assign nd = dir_q ? ($signed({2'b00, duty_q}) + STEP_S)
                      : ($signed({2'b00, duty_q}) - STEP_S);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            en_q    <= 4'b0000;
            cnt_q   <= '0;
            v_q     <= '0;
            i_q     <= '0;
            p_q     <= '0;
            pp_q    <= '0;
            duty_q  <= DUTY_W'(DUTY_INIT);
            dir_q   <= 1'b1;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            i_q     <= i_d;
            p_q     <= p_d;
            pp_q    <= pp_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        i_d     = i_q;
        p_d     = p_q;
        pp_d    = pp_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        iter_d  = iter_q;
        en_d    = 4'b0000;

        if (state_q != ST_IDLE && !run) begin
            // Abandon the partial iteration; tracking state is left untouched.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (run) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == CW'(SETTLE - 1)) state_d = ST_SAMPLE;
                    else cnt_d = cnt_q + 1'b1;
                end
                ST_SAMPLE: begin
                    v_d     = v_in;
                    i_d     = i_in;
                    state_d = ST_MULT;
                end
                ST_MULT: begin
                    p_d     = PW'(v_q) * PW'(i_q);
                    state_d = ST_COMPARE;
                end
                ST_COMPARE: begin
                    if (p_q < pp_q) dir_d = ~dir_q;
                    state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (!hold) begin
                        if (nd > MAX_S) begin
                            duty_d = DUTY_W'(DUTY_MAX);
                            dir_d  = 1'b0;
                        end else if (nd < MIN_S) begin
                            duty_d = DUTY_W'(DUTY_MIN);
                            dir_d  = 1'b1;
                        end else begin
                            duty_d = nd[DUTY_W-1:0];
                        end
                    end
                    pp_d    = p_q;
                    iter_d  = iter_q + 16'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_SETTLE:             en_d = 4'b0001;
            ST_SAMPLE:             en_d = 4'b0010;
            ST_MULT, ST_COMPARE:   en_d = 4'b0100;
            ST_UPDATE:             en_d = 4'b1000;
            default:               en_d = 4'b0000;
        endcase
    end

    assign duty  = duty_q;
    assign en    = en_q;
    assign state = state_q;
    assign dir   = dir_q;
    assign iter  = iter_q;

endmodule
